// File: rtl/vga_text_ctrl_if.sv
// Bundles the signals exchanged between the VGA text controller and its
// surroundings: the glyph/colour feed, the stage-0 pixel addresses and the
// registered video output.
//   master : the controller (drives addresses, syncs and colour).
//   slave  : the client (drives enable, mode, glyph bit and colours).
interface vga_text_ctrl_if;
    logic        en;
    logic        mode;
    logic        rom_data;
    logic [23:0] pix_rgb;
    logic [23:0] fg_rgb;
    logic [23:0] bg_rgb;
    logic [9:0]  h_addr;
    logic [9:0]  v_addr;
    logic [6:0]  cell_x;
    logic [4:0]  cell_y;
    logic [3:0]  pix_x;
    logic [4:0]  pix_y;
    logic        hsync;
    logic        vsync;
    logic        valid;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        frame_start;
    logic        line_start;

    modport master (
        input  en, mode, rom_data, pix_rgb, fg_rgb, bg_rgb,
        output h_addr, v_addr, cell_x, cell_y, pix_x, pix_y,
        output hsync, vsync, valid, vga_r, vga_g, vga_b, frame_start, line_start
    );

    modport slave (
        output en, mode, rom_data, pix_rgb, fg_rgb, bg_rgb,
        input  h_addr, v_addr, cell_x, cell_y, pix_x, pix_y,
        input  hsync, vsync, valid, vga_r, vga_g, vga_b, frame_start, line_start
    );
endinterface

// File: rtl/vga_text_ctrl.sv
// VGA text-mode timing and pixel controller.
// Stage 0 : horizontal/vertical counters plus the active-area address,
//           character cell index and offset within the cell, all registered
//           so they always describe the same pixel as hcnt/vcnt.
// Stage 1 : syncs, valid, line/frame pulses and the colour, registered one
//           cycle after the stage-0 pixel they belong to.
// Ports:
//   pclk  - pixel clock
//   reset - asynchronous active-low reset
//   bus   - vga_text_ctrl_if master (see interface for the signal list)
module vga_text_ctrl #(
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int CELL_W   = 9,
    parameter int CELL_H   = 16,
    parameter int SYNC_POL = 0
) (
    input  logic            pclk,
    input  logic            reset,
    vga_text_ctrl_if.master bus
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    // One spare code point so the end-of-active bound fits even with no porch.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_START = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_END   = HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [HW-1:0] H_SYEND = HW'(H_SYNC);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_START = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_END   = VW'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [VW-1:0] V_SYEND = VW'(V_SYNC);
    localparam logic [3:0]    PX_LAST = 4'(CELL_W - 1);
    localparam logic [4:0]    PY_LAST = 5'(CELL_H - 1);
    localparam logic          SYNC_ON = (SYNC_POL != 0);

    logic [HW-1:0] hcnt_r, hcnt_nxt_s;
    logic [VW-1:0] vcnt_r, vcnt_nxt_s;
    logic [9:0]    h_addr_r, h_addr_nxt_s, v_addr_r, v_addr_nxt_s;
    logic [6:0]    cell_x_r, cell_x_nxt_s;
    logic [4:0]    cell_y_r, cell_y_nxt_s;
    logic [3:0]    pix_x_r, pix_x_nxt_s;
    logic [4:0]    pix_y_r, pix_y_nxt_s;
    logic          line_wrap_s, h_act_nxt_s, v_act_nxt_s, h_act_s, v_act_s;
    logic [23:0]   rgb_nxt_s, rgb_r;
    logic          hsync_r, vsync_r, valid_r, frame_start_r, line_start_r;

    // Next counter position and the stage-0 address fields that go with it.
    always_comb begin
        line_wrap_s = (hcnt_r == H_LAST);
        if (line_wrap_s) begin
            hcnt_nxt_s = '0;
            if (vcnt_r == V_LAST) begin
                vcnt_nxt_s = '0;
            end else begin
                vcnt_nxt_s = vcnt_r + VW'(1);
            end
        end else begin
            hcnt_nxt_s = hcnt_r + HW'(1);
            vcnt_nxt_s = vcnt_r;
        end

        h_act_nxt_s  = (hcnt_nxt_s >= H_START) && (hcnt_nxt_s < H_END);
        v_act_nxt_s  = (vcnt_nxt_s >= V_START) && (vcnt_nxt_s < V_END);
        h_addr_nxt_s = h_act_nxt_s ? 10'(hcnt_nxt_s - H_START) : 10'd0;
        v_addr_nxt_s = v_act_nxt_s ? 10'(vcnt_nxt_s - V_START) : 10'd0;

        // Cell counters restart at the first active pixel and step on every
        // further active pixel; a short last cell still gets its own index.
        if (h_act_nxt_s && (hcnt_nxt_s != H_START)) begin
            if (pix_x_r == PX_LAST) begin
                pix_x_nxt_s  = 4'd0;
                cell_x_nxt_s = cell_x_r + 7'd1;
            end else begin
                pix_x_nxt_s  = pix_x_r + 4'd1;
                cell_x_nxt_s = cell_x_r;
            end
        end else begin
            pix_x_nxt_s  = 4'd0;
            cell_x_nxt_s = 7'd0;
        end

        // Row counters only move when the line changes.
        if (!line_wrap_s) begin
            pix_y_nxt_s  = pix_y_r;
            cell_y_nxt_s = cell_y_r;
        end else if (v_act_nxt_s && (vcnt_nxt_s != V_START)) begin
            if (pix_y_r == PY_LAST) begin
                pix_y_nxt_s  = 5'd0;
                cell_y_nxt_s = cell_y_r + 5'd1;
            end else begin
                pix_y_nxt_s  = pix_y_r + 5'd1;
                cell_y_nxt_s = cell_y_r;
            end
        end else begin
            pix_y_nxt_s  = 5'd0;
            cell_y_nxt_s = 5'd0;
        end
    end

    // Activity of the current stage-0 pixel and the colour it will display.
    // rom_data/pix_rgb are sampled alongside the addresses they answer, so
    // the resulting colour lines up with valid on the next cycle.
    always_comb begin
        h_act_s = (hcnt_r >= H_START) && (hcnt_r < H_END);
        v_act_s = (vcnt_r >= V_START) && (vcnt_r < V_END);
        if (!(h_act_s && v_act_s)) begin
            rgb_nxt_s = 24'h000000;
        end else if (bus.mode) begin
            rgb_nxt_s = bus.pix_rgb;
        end else if (bus.rom_data) begin
            rgb_nxt_s = bus.fg_rgb;
        end else begin
            rgb_nxt_s = bus.bg_rgb;
        end
    end

    // Stage 0: timing counters and address registers.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            hcnt_r   <= '0;
            vcnt_r   <= '0;
            h_addr_r <= 10'd0;
            v_addr_r <= 10'd0;
            cell_x_r <= 7'd0;
            cell_y_r <= 5'd0;
            pix_x_r  <= 4'd0;
            pix_y_r  <= 5'd0;
        end else if (bus.en) begin
            hcnt_r   <= hcnt_nxt_s;
            vcnt_r   <= vcnt_nxt_s;
            h_addr_r <= h_addr_nxt_s;
            v_addr_r <= v_addr_nxt_s;
            cell_x_r <= cell_x_nxt_s;
            cell_y_r <= cell_y_nxt_s;
            pix_x_r  <= pix_x_nxt_s;
            pix_y_r  <= pix_y_nxt_s;
        end
    end

    // Stage 1: syncs, pulses, valid and colour for the current stage-0 pixel.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            hsync_r       <= ~SYNC_ON;
            vsync_r       <= ~SYNC_ON;
            valid_r       <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            rgb_r         <= 24'h000000;
        end else if (bus.en) begin
            hsync_r       <= (hcnt_r < H_SYEND) ? SYNC_ON : ~SYNC_ON;
            vsync_r       <= (vcnt_r < V_SYEND) ? SYNC_ON : ~SYNC_ON;
            valid_r       <= h_act_s && v_act_s;
            line_start_r  <= (hcnt_r == '0);
            frame_start_r <= (hcnt_r == '0) && (vcnt_r == '0);
            rgb_r         <= rgb_nxt_s;
        end
    end

    assign bus.h_addr      = h_addr_r;
    assign bus.v_addr      = v_addr_r;
    assign bus.cell_x      = cell_x_r;
    assign bus.cell_y      = cell_y_r;
    assign bus.pix_x       = pix_x_r;
    assign bus.pix_y       = pix_y_r;
    assign bus.hsync       = hsync_r;
    assign bus.vsync       = vsync_r;
    assign bus.valid       = valid_r;
    assign bus.line_start  = line_start_r;
    assign bus.frame_start = frame_start_r;
    assign bus.vga_r       = rgb_r[23:16];
    assign bus.vga_g       = rgb_r[15:8];
    assign bus.vga_b       = rgb_r[7:0];
endmodule

// File: tb/tb_vga_text_ctrl.sv
// Self-checking bench for vga_text_ctrl on a reduced raster (29 x 15 with
// 3 x 4 cells, active-high syncs) so whole frames fit in a short run.
// A position model (pixel = enabled cycles since reset, split with / and %)
// is compared against the DUT every cycle; directed checks pin the model.
module tb_vga_text_ctrl;
    localparam int HS = 4, HB = 3, HA = 20, HF = 2;
    localparam int VS = 2, VB = 2, VA = 10, VF = 1;
    localparam int CW = 3, CH = 4, POL = 1;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FT = HT * VT;
    localparam logic SON = 1'b1;

    logic pclk  = 1'b0;
    logic rst_n = 1'b0;
    int n_tests = 0;
    int n_fail  = 0;
    int mt      = 0;
    int wcyc    = 0;
    int hs_cnt = 0, vs_cnt = 0, fs_cnt = 0, ls_cnt = 0, va_cnt = 0;
    logic        e_hs = 1'b0, e_vs = 1'b0, e_valid = 1'b0, e_ls = 1'b0, e_fs = 1'b0;
    logic [23:0] e_rgb = 24'h000000;

    vga_text_ctrl_if vif();

    vga_text_ctrl #(
        .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
        .CELL_W(CW), .CELL_H(CH), .SYNC_POL(POL)
    ) dut (
        .pclk  (pclk),
        .reset (rst_n),
        .bus   (vif)
    );

    always #5 pclk = ~pclk;

    function automatic int hpos(int t);
        return t % HT;
    endfunction
    function automatic int vpos(int t);
        return (t / HT) % VT;
    endfunction
    function automatic bit hact(int t);
        return (hpos(t) >= HS + HB) && (hpos(t) < HS + HB + HA);
    endfunction
    function automatic bit vact(int t);
        return (vpos(t) >= VS + VB) && (vpos(t) < VS + VB + VA);
    endfunction
    function automatic int haddr(int t);
        return hact(t) ? hpos(t) - (HS + HB) : 0;
    endfunction
    function automatic int vaddr(int t);
        return vact(t) ? vpos(t) - (VS + VB) : 0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h (pos %0d, cycle %0d)", name, act, exp, mt, wcyc);
        end
    endtask

    // Model: what the registered outputs must show after each enabled edge.
    always @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            mt      <= 0;
            e_hs    <= ~SON;
            e_vs    <= ~SON;
            e_valid <= 1'b0;
            e_ls    <= 1'b0;
            e_fs    <= 1'b0;
            e_rgb   <= 24'h000000;
        end else if (vif.en) begin
            e_hs    <= (hpos(mt) < HS) ? SON : ~SON;
            e_vs    <= (vpos(mt) < VS) ? SON : ~SON;
            e_valid <= hact(mt) && vact(mt);
            e_ls    <= (hpos(mt) == 0);
            e_fs    <= ((mt % FT) == 0);
            if (!(hact(mt) && vact(mt)))
                e_rgb <= 24'h000000;
            else if (vif.mode)
                e_rgb <= vif.pix_rgb;
            else
                e_rgb <= vif.rom_data ? vif.fg_rgb : vif.bg_rgb;
            mt <= mt + 1;
        end
    end

    // Every-cycle comparison of DUT against the model.
    always @(negedge pclk) begin
        check("stage0",
              64'({vif.h_addr, vif.v_addr, vif.cell_x, vif.cell_y, vif.pix_x, vif.pix_y}),
              64'({10'(haddr(mt)), 10'(vaddr(mt)), 7'(haddr(mt) / CW), 5'(vaddr(mt) / CH),
                   4'(haddr(mt) % CW), 5'(vaddr(mt) % CH)}));
        check("stage1",
              64'({vif.hsync, vif.vsync, vif.valid, vif.line_start, vif.frame_start,
                   vif.vga_r, vif.vga_g, vif.vga_b}),
              64'({e_hs, e_vs, e_valid, e_ls, e_fs, e_rgb}));
    end

    // Output statistics over the first full frame (positions 0..FT-1).
    always @(negedge pclk) begin
        if (rst_n && mt >= 1 && mt <= FT) begin
            hs_cnt <= hs_cnt + int'(vif.hsync == SON);
            vs_cnt <= vs_cnt + int'(vif.vsync == SON);
            fs_cnt <= fs_cnt + int'(vif.frame_start);
            ls_cnt <= ls_cnt + int'(vif.line_start);
            va_cnt <= va_cnt + int'(vif.valid);
        end
    end

    task automatic step();
        @(negedge pclk);
        wcyc++;
        vif.rom_data = ~vif.rom_data;
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (mt < target && guard < 2000) begin
            step();
            guard++;
        end
        check("run_to", 64'(mt), 64'(target));
    endtask

    logic [23:0] c0, c1;
    logic [63:0] snap;
    int w0;
    bit found;

    initial begin
        vif.en = 1'b0; vif.mode = 1'b0; vif.rom_data = 1'b0;
        vif.pix_rgb = 24'h000000; vif.fg_rgb = 24'hFFFFFF; vif.bg_rgb = 24'h000080;
        repeat (3) step();
        check("rst_hsync", 64'(vif.hsync), 64'd0);
        check("rst_vsync", 64'(vif.vsync), 64'd0);
        check("rst_valid", 64'(vif.valid), 64'd0);
        check("rst_pulses", 64'({vif.frame_start, vif.line_start}), 64'd0);
        check("rst_rgb", 64'({vif.vga_r, vif.vga_g, vif.vga_b}), 64'd0);

        rst_n = 1'b1;
        vif.en = 1'b1;
        step();
        check("first_fs", 64'(vif.frame_start), 64'd1);
        check("first_ls", 64'(vif.line_start), 64'd1);
        check("first_syncs", 64'({vif.hsync, vif.vsync}), 64'd3);
        step();
        check("blank_rgb", 64'({vif.vga_r, vif.vga_g, vif.vga_b}), 64'd0);

        run_to(123);
        check("fp_addr", 64'({vif.h_addr, vif.v_addr}), 64'd0);
        check("fp_cell", 64'({vif.cell_x, vif.cell_y, vif.pix_x, vif.pix_y}), 64'd0);
        check("fp_valid0", 64'(vif.valid), 64'd0);
        step();
        check("fp_valid1", 64'(vif.valid), 64'd1);
        c0 = {vif.vga_r, vif.vga_g, vif.vga_b};
        step();
        c1 = {vif.vga_r, vif.vga_g, vif.vga_b};
        check("alt_rgb", 64'((c0 != c1) && (c0 == 24'hFFFFFF || c0 == 24'h000080)
                             && (c1 == 24'hFFFFFF || c1 == 24'h000080)), 64'd1);

        run_to(128);
        check("h5", 64'({vif.h_addr, vif.cell_x, vif.pix_x}), 64'({10'd5, 7'd1, 4'd2}));
        run_to(142);
        check("h19", 64'({vif.h_addr, vif.cell_x, vif.pix_x}), 64'({10'd19, 7'd6, 4'd1}));
        run_to(384);
        check("v9", 64'({vif.v_addr, vif.cell_y, vif.pix_y}), 64'({10'd9, 5'd2, 5'd1}));
        run_to(FT + 1);
        check("fs_period", 64'(vif.frame_start), 64'd1);
        check("hs_count", 64'(hs_cnt), 64'd60);
        check("vs_count", 64'(vs_cnt), 64'd58);
        check("fs_count", 64'(fs_cnt), 64'd1);
        check("ls_count", 64'(ls_cnt), 64'd15);
        check("valid_count", 64'(va_cnt), 64'd200);

        run_to(503);
        snap = 64'({vif.h_addr, vif.cell_x, vif.pix_x, vif.hsync, vif.valid,
                    vif.vga_r, vif.vga_g, vif.vga_b});
        w0 = wcyc;
        vif.en = 1'b0;
        repeat (10) step();
        check("freeze", 64'({vif.h_addr, vif.cell_x, vif.pix_x, vif.hsync, vif.valid,
                             vif.vga_r, vif.vga_g, vif.vga_b}), snap);
        vif.en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (vif.line_start) found = 1'b1;
        end
        check("line_late", 64'(wcyc - w0), 64'd30);

        run_to(561);
        vif.mode = 1'b1;
        vif.pix_rgb = 24'h123456;
        step();
        check("mode_rgb", 64'({vif.vga_r, vif.vga_g, vif.vga_b}), 64'h123456);
        for (int i = 0; i < 6; i++) begin
            vif.pix_rgb = 24'(wcyc * 7919);
            step();
        end
        vif.mode = 1'b0;

        run_to(735);
        #1 rst_n = 1'b0;
        #1;
        check("abort_idle", 64'({vif.hsync, vif.vsync, vif.valid}), 64'd0);
        check("abort_addr", 64'({vif.h_addr, vif.v_addr}), 64'd0);
        check("abort_rgb", 64'({vif.vga_r, vif.vga_g, vif.vga_b}), 64'd0);
        repeat (3) step();
        check("hold_idle", 64'({vif.hsync, vif.vsync}), 64'd0);
        #1 rst_n = 1'b1;
        step();
        check("rel_fs", 64'(vif.frame_start), 64'd1);
        check("rel_syncs", 64'({vif.hsync, vif.vsync}), 64'd3);
        repeat (40) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
